// File: rtl/uart_autobaud_rx_if.sv
// Serial-side and byte-side signal bundle for uart_autobaud_rx.
// The receiver uses the slave view; the line driver / byte consumer uses master.
interface uart_autobaud_rx_if #(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 16
);
    logic                 i_uart_rx;
    logic                 i_relock;
    logic [DATA_BITS-1:0] o_uart_data;
    logic                 o_uart_data_vld;
    logic                 o_parity_err;
    logic                 o_frame_err;
    logic                 o_locked;
    logic [CNT_W-1:0]     o_bit_cycles;

    modport slave (
        input  i_uart_rx, i_relock,
        output o_uart_data, o_uart_data_vld, o_parity_err, o_frame_err,
               o_locked, o_bit_cycles
    );

    modport master (
        output i_uart_rx, i_relock,
        input  o_uart_data, o_uart_data_vld, o_parity_err, o_frame_err,
               o_locked, o_bit_cycles
    );
endinterface

// File: rtl/uart_autobaud_rx.sv
// Self-calibrating UART receiver: measures a 0x55 sync byte to learn the bit
// period, then receives DATA_BITS/PARITY frames and flags parity/framing errors.
module uart_autobaud_rx #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int CNT_W       = 16,
    parameter int MIN_BIT_CYC = 16,
    parameter int ERR_RELOCK  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    uart_autobaud_rx_if.slave io_bus
);
    localparam int               TW       = CNT_W + 3;
    localparam logic [CNT_W-1:0] MIN_BC   = CNT_W'(MIN_BIT_CYC);
    localparam logic [7:0]       ERR_LIM  = 8'(ERR_RELOCK);
    localparam logic [3:0]       LAST_IDX = 4'(DATA_BITS - 1);
    localparam logic             PAR_ODD  = (PARITY == 1);

    typedef enum logic [3:0] {
        S_CAL_IDLE, S_CAL_MEAS, S_CAL_STOP, S_IDLE, S_START,
        S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t               r_state;
    logic [1:0]           r_sync;
    logic                 r_prev;
    logic [TW-1:0]        r_total;
    logic [TW-1:0]        r_ivl;
    logic [TW-1:0]        r_ivl_min;
    logic [TW-1:0]        r_ivl_max;
    logic [2:0]           r_edge_cnt;
    logic [CNT_W-1:0]     r_bit;
    // One extra bit so the 1.5-period calibration wait cannot overflow.
    logic [CNT_W:0]       r_tmr;
    logic [3:0]           r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bad;
    logic [7:0]           r_err_cnt;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_vld;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_locked;
    logic [CNT_W-1:0]     r_bit_out;

    logic                 w_rx;
    logic                 w_fall;
    logic [TW-1:0]        w_total_nxt;
    logic [TW-1:0]        w_ivl_nxt;
    logic [TW-1:0]        w_spread;
    logic [CNT_W-1:0]     w_meas_bit;
    logic [CNT_W-1:0]     w_half;
    logic [CNT_W:0]       w_tmr_nxt;
    logic [CNT_W:0]       w_cal_wait;

    assign w_rx        = r_sync[1];
    assign w_fall      = r_prev & ~w_rx;
    // Counts include the current clock, so eight bit periods give exactly 8*P.
    assign w_total_nxt = r_total + 1'b1;
    assign w_ivl_nxt   = r_ivl + 1'b1;
    assign w_meas_bit  = w_total_nxt[TW-1:3];
    assign w_spread    = r_ivl_max - r_ivl_min;
    assign w_half      = r_bit >> 1;
    assign w_tmr_nxt   = r_tmr + 1'b1;
    assign w_cal_wait  = {1'b0, r_bit} + {2'b00, r_bit[CNT_W-1:1]};

    assign io_bus.o_uart_data     = r_data;
    assign io_bus.o_uart_data_vld = r_vld;
    assign io_bus.o_parity_err    = r_perr;
    assign io_bus.o_frame_err     = r_ferr;
    assign io_bus.o_locked        = r_locked;
    assign io_bus.o_bit_cycles    = r_bit_out;

    // Two-flop synchroniser plus edge history; idle line is high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], io_bus.i_uart_rx};
            r_prev <= r_sync[1];
        end
    end

    // Calibration and frame-reception FSM with registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_CAL_IDLE;
            r_total    <= '0;
            r_ivl      <= '0;
            r_ivl_min  <= '1;
            r_ivl_max  <= '0;
            r_edge_cnt <= '0;
            r_bit      <= '0;
            r_tmr      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_err_cnt  <= '0;
            r_data     <= '0;
            r_vld      <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_locked   <= 1'b0;
            r_bit_out  <= '0;
        end else begin
            r_vld  <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            if (io_bus.i_relock) begin
                // Relock wins over anything else happening this cycle.
                r_state   <= S_CAL_IDLE;
                r_locked  <= 1'b0;
                r_bit_out <= '0;
                r_err_cnt <= '0;
            end else begin
                case (r_state)
                    S_CAL_IDLE: begin
                        if (w_fall) begin
                            r_total    <= '0;
                            r_ivl      <= '0;
                            r_ivl_min  <= '1;
                            r_ivl_max  <= '0;
                            r_edge_cnt <= 3'd1;
                            r_state    <= S_CAL_MEAS;
                        end
                    end
                    S_CAL_MEAS: begin
                        r_total <= w_total_nxt;
                        r_ivl   <= w_ivl_nxt;
                        if (&r_total) begin
                            r_state <= S_CAL_IDLE;
                        end else if (w_fall) begin
                            r_ivl      <= '0;
                            r_edge_cnt <= r_edge_cnt + 1'b1;
                            if (w_ivl_nxt < r_ivl_min) r_ivl_min <= w_ivl_nxt;
                            if (w_ivl_nxt > r_ivl_max) r_ivl_max <= w_ivl_nxt;
                            if (r_edge_cnt == 3'd4) begin
                                r_bit   <= w_meas_bit;
                                r_tmr   <= '0;
                                r_state <= S_CAL_STOP;
                            end
                        end
                    end
                    S_CAL_STOP: begin
                        r_tmr <= w_tmr_nxt;
                        if (w_tmr_nxt == w_cal_wait) begin
                            if (w_rx && (r_bit >= MIN_BC) &&
                                (w_spread <= {3'b000, w_half})) begin
                                r_bit_out <= r_bit;
                                r_locked  <= 1'b1;
                                r_err_cnt <= '0;
                                r_state   <= S_IDLE;
                            end else begin
                                r_state <= S_CAL_IDLE;
                            end
                        end
                    end
                    S_IDLE: begin
                        if (w_fall) begin
                            r_tmr     <= '0;
                            r_par_bad <= 1'b0;
                            r_state   <= S_START;
                        end
                    end
                    S_START: begin
                        r_tmr <= w_tmr_nxt;
                        if (w_tmr_nxt == {1'b0, w_half}) begin
                            r_tmr <= '0;
                            r_idx <= '0;
                            r_state <= w_rx ? S_IDLE : S_DATA;
                        end
                    end
                    S_DATA: begin
                        r_tmr <= w_tmr_nxt;
                        if (w_tmr_nxt == {1'b0, r_bit}) begin
                            r_tmr   <= '0;
                            r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
                            r_idx   <= r_idx + 1'b1;
                            if (r_idx == LAST_IDX)
                                r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end
                    S_PARITY: begin
                        r_tmr <= w_tmr_nxt;
                        if (w_tmr_nxt == {1'b0, r_bit}) begin
                            r_tmr     <= '0;
                            r_par_bad <= (^r_shift) ^ w_rx ^ PAR_ODD;
                            r_state   <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        r_tmr <= w_tmr_nxt;
                        if (w_tmr_nxt == {1'b0, r_bit}) begin
                            r_tmr <= '0;
                            if (w_rx) begin
                                // Mid stop bit: hand off and rearm for a back-to-back start.
                                r_vld     <= 1'b1;
                                r_perr    <= r_par_bad;
                                r_data    <= r_shift;
                                r_err_cnt <= '0;
                                r_state   <= S_IDLE;
                            end else begin
                                r_ferr <= 1'b1;
                                if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 1'b1;
                                r_state <= S_WAIT_HIGH;
                            end
                        end
                    end
                    S_WAIT_HIGH: begin
                        if (w_rx) begin
                            if ((ERR_RELOCK != 0) && (r_err_cnt >= ERR_LIM)) begin
                                r_locked  <= 1'b0;
                                r_bit_out <= '0;
                                r_err_cnt <= '0;
                                r_state   <= S_CAL_IDLE;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    default: r_state <= S_CAL_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_autobaud_rx.sv
// Directed bench for uart_autobaud_rx: calibration, reception, relock,
// framing/parity errors, error-driven relock and glitch rejection.
module tb_uart_autobaud_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    uart_autobaud_rx_if #(.DATA_BITS(8), .CNT_W(16)) bus_a ();
    uart_autobaud_rx_if #(.DATA_BITS(7), .CNT_W(16)) bus_b ();

    uart_autobaud_rx #(.DATA_BITS(8), .PARITY(0), .CNT_W(16), .MIN_BIT_CYC(16),
                       .ERR_RELOCK(4)) u_dut_a (.i_clk(clk), .i_rst(rst), .io_bus(bus_a));
    uart_autobaud_rx #(.DATA_BITS(7), .PARITY(2), .CNT_W(16), .MIN_BIT_CYC(16),
                       .ERR_RELOCK(4)) u_dut_b (.i_clk(clk), .i_rst(rst), .io_bus(bus_b));

    int         a_vld = 0, a_ferr = 0, a_perr = 0, b_vld = 0, b_ferr = 0;
    logic [7:0] a_q[$];
    logic [6:0] b_q[$];
    logic       b_pq[$];

    // Collect strobes away from the active edge.
    always @(negedge clk) begin
        if (bus_a.o_uart_data_vld) begin a_vld++; a_q.push_back(bus_a.o_uart_data); end
        if (bus_a.o_frame_err)  a_ferr++;
        if (bus_a.o_parity_err) a_perr++;
        if (bus_b.o_uart_data_vld) begin
            b_vld++; b_q.push_back(bus_b.o_uart_data); b_pq.push_back(bus_b.o_parity_err);
        end
        if (bus_b.o_frame_err) b_ferr++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] qa(input int i);
        return (i < a_q.size()) ? {24'h0, a_q[i]} : 32'hDEAD;
    endfunction

    function automatic logic [31:0] qb(input int i);
        return (i < b_q.size()) ? {25'h0, b_q[i]} : 32'hDEAD;
    endfunction

    function automatic logic [31:0] qbp(input int i);
        return (i < b_pq.size()) ? {31'h0, b_pq[i]} : 32'hDEAD;
    endfunction

    task automatic drv(input int sel, input logic v, input int cyc);
        if (sel == 0) bus_a.i_uart_rx = v; else bus_b.i_uart_rx = v;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic frame(input int sel, input logic [8:0] d, input int nb, input bit has_par,
                         input logic pbit, input logic stopv, input int p);
        drv(sel, 1'b0, p);
        for (int i = 0; i < nb; i++) drv(sel, d[i], p);
        if (has_par) drv(sel, pbit, p);
        drv(sel, stopv, p);
        if (!stopv) drv(sel, 1'b1, p);
    endtask

    task automatic relock_a();
        bus_a.i_relock = 1'b1;
        @(negedge clk);
        bus_a.i_relock = 1'b0;
    endtask

    initial begin
        int n0;
        int lens[10];
        bus_a.i_uart_rx = 1'b1; bus_a.i_relock = 1'b0;
        bus_b.i_uart_rx = 1'b1; bus_b.i_relock = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_locked", {31'h0, bus_a.o_locked}, 0);
        chk("rst_bitcyc", {16'h0, bus_a.o_bit_cycles}, 0);
        chk("rst_data", {24'h0, bus_a.o_uart_data}, 0);
        chk("rst_vld", {31'h0, bus_a.o_uart_data_vld}, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_locked", {31'h0, bus_a.o_locked}, 0);

        // Calibrate at 434 clocks/bit, receive one byte.
        frame(0, 9'h055, 8, 0, 0, 1, 434);
        chk("lock434", {31'h0, bus_a.o_locked}, 1);
        chk("bc434", {16'h0, bus_a.o_bit_cycles}, 434);
        chk("sync_no_vld", a_vld, 0);
        frame(0, 9'h0A5, 8, 0, 0, 1, 434);
        chk("vld434", a_vld, 1);
        chk("data434", qa(0), 32'hA5);

        // Relock in the middle of 0xF0; remaining line has no falling edge.
        drv(0, 1'b0, 2 * 434);
        relock_a();
        drv(0, 1'b0, 3 * 434 - 1);
        drv(0, 1'b1, 5 * 434);
        chk("abort_no_vld", a_vld, 1);
        chk("abort_locked", {31'h0, bus_a.o_locked}, 0);
        chk("abort_bc", {16'h0, bus_a.o_bit_cycles}, 0);

        // Recalibrate at 80 clocks/bit, then 0x55, 0x01..0x27 back-to-back.
        frame(0, 9'h055, 8, 0, 0, 1, 80);
        chk("lock80", {31'h0, bus_a.o_locked}, 1);
        chk("bc80", {16'h0, bus_a.o_bit_cycles}, 80);
        n0 = a_vld;
        frame(0, 9'h055, 8, 0, 0, 1, 80);
        for (int k = 1; k <= 'h27; k++) frame(0, 9'(k), 8, 0, 0, 1, 80);
        chk("burst_cnt", a_vld - n0, 40);
        chk("burst_d0", qa(n0), 32'h55);
        for (int k = 1; k <= 'h27; k++) chk("burst_dk", qa(n0 + k), k);
        chk("burst_ferr", a_ferr, 0);
        chk("burst_perr", a_perr, 0);

        // Bad stop bit, then a clean frame.
        frame(0, 9'h03C, 8, 0, 0, 0, 80);
        chk("ferr_cnt", a_ferr, 1);
        chk("ferr_no_vld", a_vld, n0 + 40);
        chk("ferr_hold_data", {24'h0, bus_a.o_uart_data}, 32'h27);
        frame(0, 9'h03C, 8, 0, 0, 1, 80);
        chk("recover_vld", a_vld, n0 + 41);
        chk("recover_data", qa(n0 + 40), 32'h3C);

        // Four consecutive bad frames drop lock; 0x7E then fails as sync.
        for (int k = 0; k < 3; k++) frame(0, 9'h03C, 8, 0, 0, 0, 80);
        chk("err3_locked", {31'h0, bus_a.o_locked}, 1);
        frame(0, 9'h03C, 8, 0, 0, 0, 80);
        chk("err4_locked", {31'h0, bus_a.o_locked}, 0);
        chk("err4_bc", {16'h0, bus_a.o_bit_cycles}, 0);
        chk("err4_ferr", a_ferr, 5);
        frame(0, 9'h07E, 8, 0, 0, 1, 80);
        chk("x7e_no_vld", a_vld, n0 + 41);
        chk("x7e_locked", {31'h0, bus_a.o_locked}, 0);

        // Sync with bit 3 stretched to 1.6 bits must be rejected.
        relock_a();
        drv(0, 1'b1, 10);
        lens = '{80, 80, 80, 80, 128, 80, 80, 80, 80, 80};
        for (int k = 0; k < 10; k++) drv(0, (k % 2) == 1, lens[k]);
        drv(0, 1'b1, 160);
        chk("stretch_locked", {31'h0, bus_a.o_locked}, 0);
        chk("stretch_bc", {16'h0, bus_a.o_bit_cycles}, 0);
        drv(0, 1'b0, 32);
        drv(0, 1'b1, 300);
        chk("glitch_unlk", {31'h0, bus_a.o_locked}, 0);

        // Locked: a 32-clock glitch is shorter than half a bit and is ignored.
        relock_a();
        drv(0, 1'b1, 10);
        frame(0, 9'h055, 8, 0, 0, 1, 80);
        chk("relock80", {16'h0, bus_a.o_bit_cycles}, 80);
        n0 = a_vld;
        drv(0, 1'b0, 32);
        drv(0, 1'b1, 800);
        chk("glitch_no_vld", a_vld, n0);
        chk("glitch_no_ferr", a_ferr, 5);
        frame(0, 9'h081, 8, 0, 0, 1, 80);
        chk("after_glitch_vld", a_vld, n0 + 1);
        chk("after_glitch_data", qa(n0), 32'h81);

        // 7 data bits, even parity: 0x5A has four ones -> parity bit 0.
        frame(1, 9'h055, 8, 0, 0, 1, 80);
        chk("b_lock", {31'h0, bus_b.o_locked}, 1);
        chk("b_bc", {16'h0, bus_b.o_bit_cycles}, 80);
        frame(1, 9'h05A, 7, 1, 1'b0, 1, 80);
        frame(1, 9'h05A, 7, 1, 1'b1, 1, 80);
        chk("b_vld", b_vld, 2);
        chk("b_d0", qb(0), 32'h5A);
        chk("b_d1", qb(1), 32'h5A);
        chk("b_perr0", qbp(0), 0);
        chk("b_perr1", qbp(1), 1);
        chk("b_ferr", b_ferr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_autobaud_rx.md
Name: uart_autobaud_rx

Overview:
Parametrised, self-calibrating UART receiver and successor to the fixed-format adaptive-baud receiver. After reset or a relock request, it measures one 0x55 sync byte on the line to derive the bit period. It then receives frames with configurable data width and parity, and reports framing and parity errors. It sits between the board RX pin and the user-side byte consumer (loopback / ethernet bridge logic) in the uart_adaptive subsystem.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
CNT_W, 16, width of bit-period counter; max bit period 2^CNT_W-1 clocks
MIN_BIT_CYC, 16, smallest accepted bit period in clocks; shorter measurements are rejected
ERR_RELOCK, 4, consecutive framing errors that force loss of lock (0 = never)

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, synchronous, active-high
i_uart_rx  in  1  asynchronous serial input, idle high
i_relock  in  1  one-cycle pulse: drop lock and recalibrate
o_uart_data  out  DATA_BITS  received data word
o_uart_data_vld  out  1  one-cycle strobe, o_uart_data valid
o_parity_err  out  1  one-cycle strobe coincident with o_uart_data_vld when parity mismatches
o_frame_err  out  1  one-cycle strobe on bad stop bit
o_locked  out  1  high while a calibrated bit period is held
o_bit_cycles  out  CNT_W  calibrated clocks per bit (0 while unlocked)

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst is synchronous, active-high.
- Reset values: all outputs 0, o_locked=0, FSM in CAL_IDLE. Reset mid-frame aborts the frame; no strobe is produced.
- Input path: i_uart_rx passes through a 2-FF synchroniser plus an edge-history register. A falling edge is prev=1 and cur=0 on the synchronised signal. All timing below is relative to the synchronised signal.
- FSM states: CAL_IDLE, CAL_MEAS, CAL_STOP, IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- CAL_IDLE: on a falling edge, clear the total counter and interval counter, set edge_cnt=1, go to CAL_MEAS.
- CAL_MEAS (0x55 frame = falling edges at bit times 0, 2, 4, 6, 8):
  - The total counter (CNT_W+3 bits) increments every clock.
  - On each falling edge, record the interval min/max and increment edge_cnt.
  - On the 5th edge: bit_cycles = total>>3 (8 bit periods). Go to CAL_STOP.
  - If the total counter saturates, return to CAL_IDLE with no lock.
- CAL_STOP: wait 3*bit_cycles/2 clocks, then sample (mid stop bit). Lock only if all three hold:
  - sample = 1;
  - bit_cycles >= MIN_BIT_CYC;
  - (max-min interval) <= bit_cycles/2.
  - On success: o_bit_cycles <= bit_cycles, o_locked <= 1, go to IDLE. Otherwise go to CAL_IDLE.
  - The sync byte is never output on o_uart_data_vld.
- IDLE: on a falling edge go to START, clearing the bit timer.
- START: at bit_cycles/2 sample the line. If 1 (glitch), return to IDLE silently. If 0, enter DATA.
- DATA: sample every bit_cycles clocks. Shift into o_uart_data LSB-first, DATA_BITS samples. Then go to PARITY if PARITY != 0, else STOP.
- PARITY: sample after bit_cycles. Odd mode: XOR of data and parity must be 1. Even mode: it must be 0. Latch the mismatch.
- STOP: sample after bit_cycles.
  - If 1: pulse o_uart_data_vld (with o_parity_err if the mismatch was latched) in the cycle after the sample. Clear the consecutive-error count. Go to IDLE. This is the stop-bit midpoint, so back-to-back frames are accepted.
  - If 0: pulse o_frame_err, no vld. Increment the consecutive-error count. Go to WAIT_HIGH.
- WAIT_HIGH: wait for line = 1, then go to IDLE. If the error count reaches ERR_RELOCK (ERR_RELOCK != 0), go to CAL_IDLE instead, with o_locked=0 and o_bit_cycles=0.
- o_uart_data holds its last value between strobes.
- i_relock: in any state, the next cycle goes to CAL_IDLE with o_locked=0 and o_bit_cycles=0. Any in-flight frame is discarded with no strobes. i_relock has priority over every same-cycle event, including a completing stop sample.
- Arithmetic: bit timer is CNT_W bits. Half period = bit_cycles>>1 (floor). No division other than shifts.

Test Plan:
1. Reset, then 0x55 at 115200 baud (50 MHz clock, 434 clk/bit), then 0x55 and 0x01..0x27 back-to-back -> o_locked=1 and o_bit_cycles=434 before the 2nd byte; exactly 40 vld strobes with data 0x55, 0x01, ..., 0x27 in order; no error strobes.
2. After lock at 115200, pulse i_relock mid-byte, then send 0x55 and 0xA3 at 9600 baud (5208 clk/bit) -> aborted byte produces no strobe; o_bit_cycles=5208; a single vld with 0xA3.
3. PARITY=2, DATA_BITS=7: sync, then 0x5A with correct parity, then 0x5A with parity bit inverted -> two vld strobes with data 0x5A; o_parity_err=0 on the first and 1 on the second.
4. Locked, send 0x3C with stop bit forced low, then a valid 0x3C -> one o_frame_err and no vld for the bad frame; vld with 0x3C after the line recovers.
5. ERR_RELOCK=4: four consecutive bad-stop frames -> o_locked falls after the 4th; a following 0x7E is consumed as a failed sync with no vld.
6. Unlocked: 0x55 with bit 3 stretched to 1.6 bits, then a 0x20-clock low glitch -> no lock; in a locked state, the same glitch produces no strobes.
